// File: rtl/sub_12.sv
// sub_12: pipelined 12-bit integer-field subtractor with valid, stall, borrow and optional clamp-at-zero
module sub_12 #(
  parameter int LATENCY = 5,
  parameter int FRAC_W  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ce_i,
  input  logic        valid_i,
  input  logic        sat_en_i,
  input  logic [11:0] data_1_i,
  input  logic [11:0] data_2_i,
  output logic [11:0] data_diff_o,
  output logic        borrow_o,
  output logic        valid_o,
  output logic        busy_o
);
  localparam int W = 12 - FRAC_W;
  logic [W-1:0]       w_a, w_b, w_d;
  logic               w_brw;
  logic [W-1:0]       r_d [LATENCY];
  logic [LATENCY-1:0] r_b, r_v;
  assign w_a   = W'(data_1_i >> FRAC_W);
  assign w_b   = W'(data_2_i >> FRAC_W);
  assign w_brw = w_a < w_b;
  // non-valid slots carry zeros so idle output data is deterministic
  assign w_d   = (!valid_i || (sat_en_i && w_brw)) ? '0 : w_a - w_b;
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      r_v <= '0;
      r_b <= '0;
      for (int i = 0; i < LATENCY; i++) r_d[i] <= '0;
    end else if (ce_i) begin
      r_v    <= {r_v[LATENCY-2:0], valid_i};
      r_b    <= {r_b[LATENCY-2:0], valid_i & w_brw};
      r_d[0] <= w_d;
      for (int i = 1; i < LATENCY; i++) r_d[i] <= r_d[i-1];
    end
  assign data_diff_o = 12'(r_d[LATENCY-1]) << FRAC_W;
  assign borrow_o    = r_b[LATENCY-1];
  assign valid_o     = r_v[LATENCY-1];
  assign busy_o      = |r_v;
endmodule
